fifo_mc_clearable: RTL and testbench



---
 rtl/fifo_mc_pkg.sv | 14 +
 rtl/fifo_mc_channel.sv | 98 +++++++++
 rtl/fifo_mc_clearable.sv | 55 +++++
 tb/tb_fifo_mc_clearable.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mc_pkg.sv
// Shared types and helpers for the multi-channel clearable FIFO.
package fifo_mc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISOLATE = 2'd1,
      CLEAR   = 2'd2
   } clr_state_e;

   function automatic int unsigned usage_width(input int unsigned log_depth);
      return log_depth + 1;
   endfunction

endpackage

// File: rtl/fifo_mc_channel.sv
// One FIFO lane: storage, binary pointers, clear FSM, fill level and almost-full.
// Optional FIFO_MC_FALL_THROUGH_EN forwards valid_i/data_i when the lane is empty.
module fifo_mc_channel import fifo_mc_pkg::*; #(
   parameter type         T              = logic [7:0],
   parameter int unsigned LOG_DEPTH      = 3,
   parameter int unsigned ALMOST_FULL_TH = 2**LOG_DEPTH - 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              clear_i,
   output logic                              clear_pending_o,
   input  T                                  data_i,
   input  logic                              valid_i,
   output logic                              ready_o,
   output T                                  data_o,
   output logic                              valid_o,
   input  logic                              ready_i,
   output logic [usage_width(LOG_DEPTH)-1:0] usage_o,
   output logic                              almost_full_o
);

   localparam int unsigned   DEPTH   = 2**LOG_DEPTH;
   localparam int unsigned   UW      = usage_width(LOG_DEPTH);
   localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
   localparam logic [UW-1:0] AF_TH_U = UW'(ALMOST_FULL_TH);

   T              mem_q [DEPTH];
   logic [UW-1:0] wptr_q, wptr_d;
   logic [UW-1:0] rptr_q, rptr_d;
   logic [UW-1:0] usage;
   clr_state_e    state_q, state_d;
   logic          pending, empty, full, push, pop, bypass;

   assign usage   = wptr_q - rptr_q;
   assign empty   = (usage == '0);
   assign full    = (usage == DEPTH_U);
   assign pending = clear_i | (state_q != IDLE);

   assign clear_pending_o = pending;
   assign ready_o         = !full && !pending;
   assign usage_o         = usage;
   assign almost_full_o   = (usage >= AF_TH_U);

`ifdef FIFO_MC_FALL_THROUGH_EN
   logic fall_through;
   assign fall_through = empty && !pending;
   assign valid_o      = fall_through ? valid_i : (!empty && !pending);
   assign data_o       = fall_through ? data_i : mem_q[rptr_q[LOG_DEPTH-1:0]];
   // A forwarded word that is taken in the same cycle never touches storage.
   assign bypass       = fall_through && valid_i && ready_i;
`else
   assign valid_o      = !empty && !pending;
   assign data_o       = mem_q[rptr_q[LOG_DEPTH-1:0]];
   assign bypass       = 1'b0;
`endif

   assign push = valid_i && ready_o && !bypass;
   assign pop  = valid_o && ready_i && !bypass;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (clear_i) state_d = ISOLATE;
         ISOLATE: state_d = CLEAR;
         CLEAR:   if (!clear_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wptr_d = wptr_q + UW'(push);
      rptr_d = rptr_q + UW'(pop);
      if (state_q == CLEAR) begin
         wptr_d = '0;
         rptr_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   // Payload storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q[LOG_DEPTH-1:0]] <= data_i;
      end
   end

endmodule

// File: rtl/fifo_mc_clearable.sv
// Single-clock multi-channel FIFO with per-channel synchronous clear.
// Define FIFO_MC_FALL_THROUGH_EN for zero-latency forwarding on empty lanes.
module fifo_mc_clearable import fifo_mc_pkg::*; #(
   parameter int unsigned NUM_CHANNELS   = 4,
   parameter int unsigned WIDTH          = 8,
   parameter type         T              = logic [WIDTH-1:0],
   parameter int unsigned LOG_DEPTH      = 3,
   parameter int unsigned ALMOST_FULL_TH = 2**LOG_DEPTH - 1
) (
   input  logic                                                 clk_i,
   input  logic                                                 rst_ni,
   input  logic [NUM_CHANNELS-1:0]                              clear_i,
   output logic [NUM_CHANNELS-1:0]                              clear_pending_o,
   input  T     [NUM_CHANNELS-1:0]                              data_i,
   input  logic [NUM_CHANNELS-1:0]                              valid_i,
   output logic [NUM_CHANNELS-1:0]                              ready_o,
   output T     [NUM_CHANNELS-1:0]                              data_o,
   output logic [NUM_CHANNELS-1:0]                              valid_o,
   input  logic [NUM_CHANNELS-1:0]                              ready_i,
   output logic [NUM_CHANNELS-1:0][usage_width(LOG_DEPTH)-1:0]  usage_o,
   output logic [NUM_CHANNELS-1:0]                              almost_full_o
);

   if (LOG_DEPTH < 1) begin : g_chk_log_depth
      $error("fifo_mc_clearable: LOG_DEPTH must be >= 1");
   end
   if (NUM_CHANNELS < 1) begin : g_chk_num_channels
      $error("fifo_mc_clearable: NUM_CHANNELS must be >= 1");
   end
   if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > 2**LOG_DEPTH) begin : g_chk_af_th
      $error("fifo_mc_clearable: ALMOST_FULL_TH must be within 1..2**LOG_DEPTH");
   end

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
      fifo_mc_channel #(
         .T              (T),
         .LOG_DEPTH      (LOG_DEPTH),
         .ALMOST_FULL_TH (ALMOST_FULL_TH)
      ) u_channel (
         .clk_i           (clk_i),
         .rst_ni          (rst_ni),
         .clear_i         (clear_i[gi]),
         .clear_pending_o (clear_pending_o[gi]),
         .data_i          (data_i[gi]),
         .valid_i         (valid_i[gi]),
         .ready_o         (ready_o[gi]),
         .data_o          (data_o[gi]),
         .valid_o         (valid_o[gi]),
         .ready_i         (ready_i[gi]),
         .usage_o         (usage_o[gi]),
         .almost_full_o   (almost_full_o[gi])
      );
   end

endmodule

// File: tb/tb_fifo_mc_clearable.sv
// Directed self-checking bench for fifo_mc_clearable (default parameters).
module tb_fifo_mc_clearable;

   logic            clk;
   logic            rst_n;
   logic [3:0]      clear_i;
   logic [3:0]      clear_pending_o;
   logic [3:0][7:0] data_i;
   logic [3:0]      valid_i;
   logic [3:0]      ready_o;
   logic [3:0][7:0] data_o;
   logic [3:0]      valid_o;
   logic [3:0]      ready_i;
   logic [3:0][3:0] usage_o;
   logic [3:0]      almost_full_o;

   int checks = 0;
   int errors = 0;

   fifo_mc_clearable dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .clear_i         (clear_i),
      .clear_pending_o (clear_pending_o),
      .data_i          (data_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .usage_o         (usage_o),
      .almost_full_o   (almost_full_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      $display("[%0t] %s obs=%0h exp=%0h", $time, tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      clear_i = '0;
      data_i  = '0;
      valid_i = '0;
      ready_i = '0;
      cyc();
      cyc();
      check("rst_ready", ready_o, 4'hF);
      check("rst_valid", valid_o, 4'h0);
      check("rst_usage", usage_o, 16'h0);
      check("rst_af", almost_full_o, 4'h0);
      check("rst_pend", clear_pending_o, 4'h0);
      rst_n = 1'b1;
      cyc();

      // Fill channel 0 with eight words while nothing is popped.
      for (int i = 0; i < 8; i++) begin
         valid_i[0] = 1'b1;
         data_i[0]  = 8'(8'h10 + i);
         #2;
         check("fill_ready", ready_o[0], 1'b1);
         check("fill_usage", usage_o[0], 4'(i));
         check("fill_af", almost_full_o[0], (i >= 7) ? 1'b1 : 1'b0);
         cyc();
      end
      valid_i[0] = 1'b0;
      #2;
      check("full_ready", ready_o[0], 1'b0);
      check("full_usage", usage_o[0], 4'd8);
      check("full_af", almost_full_o[0], 1'b1);

      // Full lane with push and pop offered together: only the pop happens.
      valid_i[0] = 1'b1;
      ready_i[0] = 1'b1;
      data_i[0]  = 8'h18;
      #2;
      check("fullpp_ready", ready_o[0], 1'b0);
      check("fullpp_valid", valid_o[0], 1'b1);
      check("fullpp_data", data_o[0], 8'h10);
      cyc();
      valid_i[0] = 1'b0;
      ready_i[0] = 1'b0;
      #2;
      check("afterpp_ready", ready_o[0], 1'b1);
      check("afterpp_usage", usage_o[0], 4'd7);

      ready_i[0] = 1'b1;
      for (int i = 1; i < 8; i++) begin
         #2;
         check("drain_valid", valid_o[0], 1'b1);
         check("drain_data", data_o[0], 8'(8'h10 + i));
         cyc();
      end
      ready_i[0] = 1'b0;
      #2;
      check("drain_usage", usage_o[0], 4'd0);
      check("drain_valid_end", valid_o[0], 1'b0);

      // Continuous traffic on channel 1 wraps the pointers.
      for (int i = 0; i < 20; i++) begin
         valid_i[1] = 1'b1;
         ready_i[1] = 1'b1;
         data_i[1]  = 8'(8'h40 + i);
         #2;
         check("wrap_usage", usage_o[1], (i == 0) ? 4'd0 : 4'd1);
         if (i > 0) check("wrap_data", data_o[1], 8'(8'h40 + i - 1));
         cyc();
      end
      valid_i[1] = 1'b0;
      #2;
      check("wrap_last", data_o[1], 8'h53);
      cyc();
      ready_i[1] = 1'b0;
      #2;
      check("wrap_empty", usage_o[1], 4'd0);

      // Channel 2 gets three entries, channel 3 one entry.
      for (int i = 0; i < 3; i++) begin
         valid_i[2] = 1'b1;
         data_i[2]  = 8'(8'h20 + i);
         valid_i[3] = (i == 0);
         data_i[3]  = 8'h33;
         cyc();
      end
      valid_i = '0;

      // Cycle t: clear pulse on channel 2 with handshakes attempted.
      clear_i    = 4'b0100;
      valid_i    = 4'b0110;
      ready_i    = 4'b0100;
      data_i[1]  = 8'h77;
      data_i[2]  = 8'h99;
      #2;
      check("clr_t_pend", clear_pending_o, 4'b0100);
      check("clr_t_valid", valid_o[2], 1'b0);
      check("clr_t_ready", ready_o[2], 1'b0);
      check("clr_t_ready1", ready_o[1], 1'b1);
      cyc();
      clear_i    = '0;
      valid_i[1] = 1'b0;
      for (int i = 1; i < 3; i++) begin
         #2;
         check("clr_pend", clear_pending_o[2], 1'b1);
         check("clr_valid", valid_o[2], 1'b0);
         check("clr_ready", ready_o[2], 1'b0);
         check("clr_usage_hold", usage_o[2], 4'd3);
         cyc();
      end
      // Cycle t+3: lane is empty and accepts again.
      ready_i   = '0;
      data_i[2] = 8'h2A;
      #2;
      check("clr_t3_usage", usage_o[2], 4'd0);
      check("clr_t3_pend", clear_pending_o, 4'b0000);
      check("clr_t3_valid", valid_o[2], 1'b0);
      check("clr_t3_ready", ready_o[2], 1'b1);
      check("clr_iso_u3", usage_o[3], 4'd1);
      check("clr_iso_d3", data_o[3], 8'h33);
      check("clr_iso_u1", usage_o[1], 4'd1);
      check("clr_iso_d1", data_o[1], 8'h77);
      check("clr_iso_u0", usage_o[0], 4'd0);
      cyc();
      valid_i = '0;
      #2;
      check("clr_repush_u", usage_o[2], 4'd1);
      check("clr_repush_d", data_o[2], 8'h2A);

      // Held clear on channel 3 with an asynchronous reset mid-sequence.
      clear_i = 4'b1000;
      cyc();
      cyc();
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_pend", clear_pending_o, 4'b1000);
      check("arst_ready", ready_o, 4'b0111);
      check("arst_valid", valid_o, 4'h0);
      check("arst_usage", usage_o, 16'h0);
      check("arst_af", almost_full_o, 4'h0);
      clear_i = 4'b0000;
      #1;
      check("arst_fsm_idle", clear_pending_o, 4'b0000);
      clear_i = 4'b1000;
      #1;
      check("arst_pend_again", clear_pending_o, 4'b1000);
      cyc();
      rst_n = 1'b1;
      #1;
      check("rel_pend", clear_pending_o[3], 1'b1);
      check("rel_ready", ready_o, 4'b0111);
      cyc();
      cyc();
      clear_i = '0;
      #2;
      check("rel_clear_state", clear_pending_o[3], 1'b1);
      cyc();
      #1;
      check("rel_idle_pend", clear_pending_o, 4'b0000);
      check("rel_idle_ready", ready_o, 4'hF);

      // Push latency on an empty lane with ready_i already high.
      valid_i[0] = 1'b1;
      ready_i[0] = 1'b1;
      data_i[0]  = 8'hAB;
      #2;
`ifdef FIFO_MC_FALL_THROUGH_EN
      check("ft_valid", valid_o[0], 1'b1);
      check("ft_data", data_o[0], 8'hAB);
      cyc();
      valid_i = '0;
      ready_i = '0;
      #2;
      check("ft_usage", usage_o[0], 4'd0);
      check("ft_valid_after", valid_o[0], 1'b0);
`else
      check("lat_valid", valid_o[0], 1'b0);
      cyc();
      valid_i = '0;
      #2;
      check("lat_valid_next", valid_o[0], 1'b1);
      check("lat_data_next", data_o[0], 8'hAB);
      cyc();
      ready_i = '0;
      #2;
      check("lat_usage", usage_o[0], 4'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
